// File: rtl/multiword_adder_seq_if.sv
// Handshake/operand bundle for the sequential multi-word adder.
// SIGNED_OVF_EN adds the ovf result flag to the bundle.
interface multiword_adder_seq_if #(
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = 32 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SIGNED_OVF_EN
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/multiword_adder_seq.sv
// Sequential WORDS x 32-bit adder: one word per cycle through a single 32-bit
// carry-select adder, LSW first. Optional macro SIGNED_OVF_EN adds ovf.
module multiword_adder_seq #(
  parameter int unsigned WORDS = 4
) (
  input logic                  clk,
  input logic                  rst,
  multiword_adder_seq_if.slave bus
);
  localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  state_t                  state_d;
  logic [WORDS-1:0][31:0]  a_reg;
  logic [WORDS-1:0][31:0]  b_reg;
  logic [WORDS-1:0][31:0]  sum_reg;
  logic [IDXW-1:0]         idx;
  logic                    carry_reg;
  logic                    cout_reg;
  logic                    in_ready_reg;
  logic                    out_valid_reg;
  logic                    last_word;
  logic [31:0]             add_s;
  logic                    add_co;

  // One shared 32-bit adder slice, fed from the current word of each operand
  csa_adder u_adder (
    .A    (a_reg[idx]),
    .B    (b_reg[idx]),
    .Cin  (carry_reg),
    .S    (add_s),
    .Cout (add_co)
  );

  assign last_word = (idx == IDXW'(WORDS - 1));

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef SIGNED_OVF_EN
  logic ovf_reg;

  // Signed overflow: like-signed operands producing a result of the other sign
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && last_word) begin
      ovf_reg <= (a_reg[WORDS-1][31] == b_reg[WORDS-1][31]) &&
                 (add_s[31] != a_reg[WORDS-1][31]);
    end
  end

  assign bus.ovf = ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      idx           <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state         <= state_d;
      in_ready_reg  <= (state_d == IDLE);
      out_valid_reg <= (state_d == DONE);
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            idx       <= '0;
          end
        end
        RUN: begin
          sum_reg[idx] <= add_s;
          carry_reg    <= add_co;
          // idx parks on the last word instead of wrapping
          if (last_word) cout_reg <= add_co;
          else           idx      <= idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
endmodule

// 32-bit carry-select adder: upper half precomputed for both incoming carries.
module csa_adder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);
  logic [16:0] lo;
  logic [16:0] hi0;
  logic [16:0] hi1;

  assign lo  = {1'b0, A[15:0]} + {1'b0, B[15:0]} + 17'(Cin);
  assign hi0 = {1'b0, A[31:16]} + {1'b0, B[31:16]};
  assign hi1 = {1'b0, A[31:16]} + {1'b0, B[31:16]} + 17'd1;

  assign S[15:0]         = lo[15:0];
  assign {Cout, S[31:16]} = lo[16] ? hi1 : hi0;
endmodule

// File: tb/tb_multiword_adder_seq.sv
// Self-checking bench for multiword_adder_seq against a wide-integer reference.
module tb_multiword_adder_seq;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 32 * WORDS;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  multiword_adder_seq_if #(.WORDS(WORDS)) bus ();
  multiword_adder_seq #(.WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < int'(WORDS); i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       output bit timeout, output int lat);
    int n = 0;
    timeout = 1'b0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.a = x; bus.b = y; bus.cin = c; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!bus.out_valid) timeout = 1'b1;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.sum !== '0) begin failures++; $display("FAIL reset_sum got=%h exp=0", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
`ifdef SIGNED_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
`endif
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[6];
    logic [W-1:0] tb[6];
    logic         tc[6];
    logic [W:0]   exp;
    bit           to;
    int           lat;
    ta[0] = '1;                      tb[0] = W'(1);          tc[0] = 1'b0;
    ta[1] = W'(5);                   tb[1] = W'(0) - W'(3);  tc[1] = 1'b0;
    ta[2] = W'(0) - W'(4);           tb[2] = W'(0) - W'(8);  tc[2] = 1'b0;
    ta[3] = '0;                      tb[3] = '0;             tc[3] = 1'b1;
    ta[4] = {1'b0, {(W-1){1'b1}}};   tb[4] = W'(1);          tc[4] = 1'b0;
    ta[5] = {1'b1, {(W-1){1'b0}}};   tb[5] = '1;             tc[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = ref_add(ta[i], tb[i], tc[i]);
      do_op(ta[i], tb[i], tc[i], to, lat);
      checks++; if (to) begin failures++; $display("FAIL dir%0d_timeout out_valid never rose", i); end
      checks++; if (lat != int'(WORDS)) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, WORDS); end
      checks++; if (bus.sum !== exp[W-1:0]) begin failures++; $display("FAIL dir%0d_sum got=%h exp=%h", i, bus.sum, exp[W-1:0]); end
      checks++; if (bus.cout !== exp[W]) begin failures++; $display("FAIL dir%0d_cout got=%b exp=%b", i, bus.cout, exp[W]); end
`ifdef SIGNED_OVF_EN
      checks++; if (bus.ovf !== ref_ovf(ta[i], tb[i], exp[W-1:0])) begin failures++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, bus.ovf, ref_ovf(ta[i], tb[i], exp[W-1:0])); end
`endif
      consume();
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_release in_ready=%b out_valid=%b exp 1/0", i, bus.in_ready, bus.out_valid); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic         c;
    logic [W:0]   exp;
    bit           to;
    int           lat;
    for (int i = 0; i < 20; i++) begin
      x = rand_wide(); y = rand_wide(); c = 1'($urandom);
      exp = ref_add(x, y, c);
      do_op(x, y, c, to, lat);
      checks++; if (to || bus.sum !== exp[W-1:0] || bus.cout !== exp[W]) begin failures++; $display("FAIL rnd%0d_result to=%0d got=%b_%h exp=%b_%h", i, to, bus.cout, bus.sum, exp[W], exp[W-1:0]); end
`ifdef SIGNED_OVF_EN
      checks++; if (bus.ovf !== ref_ovf(x, y, exp[W-1:0])) begin failures++; $display("FAIL rnd%0d_ovf got=%b exp=%b", i, bus.ovf, ref_ovf(x, y, exp[W-1:0])); end
`endif
      consume();
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] x, y;
    logic [W:0]   exp;
    bit           to;
    int           lat;
    x = rand_wide(); y = rand_wide();
    exp = ref_add(x, y, 1'b1);
    do_op(x, y, 1'b1, to, lat);
    checks++; if (to) begin failures++; $display("FAIL bp_timeout out_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin bus.a = rand_wide(); bus.b = rand_wide(); bus.in_valid = 1'b1; end
      else bus.in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== exp[W-1:0] || bus.cout !== exp[W]) begin
        failures++;
        $display("FAIL bp_hold%0d out_valid=%b in_ready=%b got=%b_%h exp=1/0 %b_%h", i, bus.out_valid, bus.in_ready, bus.cout, bus.sum, exp[W], exp[W-1:0]);
      end
    end
    bus.in_valid = 1'b0;
    consume();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== exp[W-1:0]) begin failures++; $display("FAIL bp_dropped out_valid=%b in_ready=%b sum=%h exp 0/1 %h", bus.out_valid, bus.in_ready, bus.sum, exp[W-1:0]); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] x, y;
    logic [W:0]   exp;
    bit           to;
    int           lat;
    bus.a = rand_wide(); bus.b = rand_wide(); bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid); end
    checks++; if (bus.sum !== '0 || bus.cout !== 1'b0) begin failures++; $display("FAIL rstmid_data got=%b_%h exp=0_0", bus.cout, bus.sum); end
    repeat (WORDS + 2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_result out_valid=%b exp=0", bus.out_valid); end
    x = rand_wide(); y = rand_wide();
    exp = ref_add(x, y, 1'b1);
    do_op(x, y, 1'b1, to, lat);
    checks++; if (to || bus.sum !== exp[W-1:0] || bus.cout !== exp[W]) begin failures++; $display("FAIL rstmid_after to=%0d got=%b_%h exp=%b_%h", to, bus.cout, bus.sum, exp[W], exp[W-1:0]); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W:0] expq[$];
    logic [W:0] e;
    logic [W-1:0] x, y;
    logic c;
    int cyc = 0, last_done = -1, sent = 0, got = 0;
    bus.out_ready = 1'b1;
    while (got < 3 && cyc < 200) begin
      if (bus.in_ready && sent < 3) begin
        x = rand_wide(); y = rand_wide(); c = 1'($urandom);
        bus.a = x; bus.b = y; bus.cin = c; bus.in_valid = 1'b1;
        expq.push_back(ref_add(x, y, c));
        sent++;
      end else bus.in_valid = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (bus.out_valid) begin
        e = expq.pop_front();
        checks++; if (bus.sum !== e[W-1:0] || bus.cout !== e[W]) begin failures++; $display("FAIL b2b%0d_result got=%b_%h exp=%b_%h", got, bus.cout, bus.sum, e[W], e[W-1:0]); end
        if (last_done >= 0) begin
          checks++; if (cyc - last_done != int'(WORDS) + 2) begin failures++; $display("FAIL b2b%0d_spacing got=%0d exp=%0d", got, cyc - last_done, WORDS + 2); end
        end
        last_done = cyc;
        got++;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (got != 3) begin failures++; $display("FAIL b2b_timeout got=%0d results exp=3", got); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_pressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multiword_adder_seq.md
Name: multiword_adder_seq

Overview:
- Sequential wide-operand adder built on one internal CSA_ADDER instance (32-bit; ports A, B, Cin, S, Cout).
- Adds two WORDS×32-bit operands one 32-bit word per cycle, least significant word first.
- Carries the adder's Cout into the next word's Cin.
- Sits directly in front of and behind CSA_ADDER: it feeds the adder's operands and registers its sum/carry, with valid/ready handshakes on both sides.

Parameters:
- WORDS, 4, number of 32-bit words per operand; legal range 1..16; total operand width W = 32*WORDS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into word 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  registered result.
- cout  output  1  carry out of the most significant word.

Behaviour:
- Reset: one clk edge with rst=1 sets state to IDLE. Resulting outputs: in_ready=1, out_valid=0, sum=0, cout=0. Word index and carry registers are cleared.
- rst has priority over every other event, including mid-RUN and DONE; any partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b into operand registers, carry_reg<=cin, idx<=0, go to RUN.
  - Input ports are not sampled after this edge.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the adder is driven combinationally: A=a_reg[32*idx+:32], B=b_reg[32*idx+:32], Cin=carry_reg.
  - At the edge: sum[32*idx+:32]<=S, carry_reg<=Cout, idx<=idx+1.
  - When idx==WORDS-1: cout<=Cout, go to DONE.
  - idx width is clog2(WORDS), minimum 1 bit; it never wraps past WORDS-1.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and cout are held stable until out_valid&&out_ready; then go to IDLE with out_valid=0 on the next cycle.
  - sum and cout keep their last values in IDLE.
- Latency: operands accepted at edge k → out_valid high after edge k+WORDS. WORDS=1 gives 1 cycle.
- Throughput: one operation per WORDS+2 cycles minimum. DONE→IDLE inserts one bubble; there is no accept in DONE.
- Arithmetic: unsigned modulo 2^W, {cout,sum} = a+b+cin exactly. Two's-complement operands give the correct W-bit wrapped result.
- in_valid while in_ready=0 is ignored; the upstream source must hold its data.
- out_ready asserted outside DONE is ignored.

Optional Feature:
- Macro SIGNED_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), set on the final RUN edge to (a_reg[W-1]==b_reg[W-1]) && (S[31]!=a_reg[W-1]), i.e. signed overflow.
  - Reset 0; held with sum in DONE.
- Not defined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WORDS=4, a=all-ones (128'hFFFF…F), b=1, cin=0 → after 4 cycles sum=0, cout=1; the carry ripples through all words.
- WORDS=4, a=5, b=-3 (128-bit two's complement), cin=0 → sum=2, cout=1. A second operation with a=-4, b=-8 → sum=-12 (128'hFFFF…FFF4), cout=1.
- a=0, b=0, cin=1 → sum=1, cout=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, sum and cout stable, in_ready=0; a new in_valid pulse during this time is dropped. Then raise out_ready → IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst for 1 cycle at idx=2 → next cycle IDLE, in_ready=1, out_valid=0, sum=0, cout=0. A subsequent operation computes correctly.
- With SIGNED_OVF_EN, WORDS=1, a=32'h7FFFFFFF, b=1 → sum=32'h80000000, ovf=1, cout=0. Then a=32'h80000000, b=32'hFFFFFFFF → sum=32'h7FFFFFFF, ovf=1, cout=1.
